// File: rtl/mem_ctrl_if.sv
// Pipeline-to-controller request/response bundle.
// master: MEM stage drives req_*; slave: mem_ctrl answers with resp_*.
interface mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Load/store controller between the MEM stage and an async-read SRAM.
// Ports: clk, reset, bus (req/resp), cs/oe/we/addr/din/dout to SRAM.
module mem_ctrl #(
  parameter int RD_WAIT    = 1,
  parameter int BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        reset,
  mem_ctrl_if.slave   bus,
  output logic        cs,
  output logic        oe,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] din,
  input  logic [31:0] dout
);

  typedef enum logic [2:0] {
    IDLE, RD, RMW_RD, WR, RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  a_size;
  logic        a_signed;
  logic [1:0]  a_off;
  logic [31:0] a_wdata;

  logic        acc;
  logic        bad;
  logic        last;
  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  byt;
  logic [15:0] hw;
  logic [31:0] ldata;
  logic [31:0] mdata;

  assign acc  = bus.req_valid && bus.req_ready;
  assign last = (cnt == 4'(RD_WAIT - 1));

  always_comb begin
    bad = (bus.req_size == 2'b11)
        | ((bus.req_size == 2'b01) & bus.req_addr[0])
        | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]));
  end

  // Lane shifts: big-endian puts byte offset 0 in the top byte.
  always_comb begin
    if (BIG_ENDIAN != 0) begin
      bsh = {~a_off, 3'b000};
      hsh = {~a_off[1], 4'b0000};
    end else begin
      bsh = {a_off, 3'b000};
      hsh = {a_off[1], 4'b0000};
    end
    byt = dout[bsh +: 8];
    hw  = dout[hsh +: 16];
  end

  always_comb begin
    ldata = dout;
    mdata = a_wdata;
    unique case (1'b1)
      a_size == 2'b00: begin
        ldata = {{24{a_signed & byt[7]}}, byt};
        mdata = (dout & ~(32'h0000_00ff << bsh))
              | ({24'h0, a_wdata[7:0]} << bsh);
      end
      a_size == 2'b01: begin
        ldata = {{16{a_signed & hw[15]}}, hw};
        mdata = (dout & ~(32'h0000_ffff << hsh))
              | ({16'h0, a_wdata[15:0]} << hsh);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      a_size         <= '0;
      a_signed       <= 1'b0;
      a_off          <= '0;
      a_wdata        <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      cs             <= 1'b0;
      oe             <= 1'b0;
      we             <= 1'b0;
      addr           <= '0;
      din            <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (acc) begin
            bus.req_ready <= 1'b0;
            a_size   <= bus.req_size;
            a_signed <= bus.req_signed;
            a_off    <= bus.req_addr[1:0];
            a_wdata  <= bus.req_wdata;
            cnt      <= '0;
            if (bad) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              addr <= {bus.req_addr[31:2], 2'b00};
              cs   <= 1'b1;
              if (!bus.req_we) begin
                state <= RD;
                oe    <= 1'b1;
              end else if (bus.req_size == 2'b10) begin
                state <= WR;
                we    <= 1'b1;
                din   <= bus.req_wdata;
              end else begin
                state <= RMW_RD;
                oe    <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (last) begin
            cs             <= 1'b0;
            oe             <= 1'b0;
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= ldata;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RMW_RD: begin
          if (last) begin
            oe    <= 1'b0;
            we    <= 1'b1;
            din   <= mdata;
            state <= WR;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR: begin
          cs             <= 1'b0;
          we             <= 1'b0;
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
